// File: rtl/cal_offset_capture_if.sv
// rtl/cal_offset_capture_if.sv - capture control handshake and calibration-memory write bus
interface cal_offset_capture_if #(
  parameter int W = 16
);
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                wr_en;
  logic [3:0]          wr_addr;
  logic signed [W-1:0] wr_data;

  modport master (
    input  start, abort,
    output busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort,
    input  busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/cal_offset_capture.sv
// rtl/cal_offset_capture.sv - averages 2**LOG2_N frames of eight channels into offset words
module cal_offset_capture #(
  parameter int W      = 16,
  parameter int LOG2_N = 8
) (
  input  logic                clk_256fs,
  input  logic                rst_n,
  input  logic                clk_fs,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic signed [W-1:0] in4,
  input  logic signed [W-1:0] in5,
  input  logic signed [W-1:0] in6,
  input  logic signed [W-1:0] in7,
  cal_offset_capture_if.master bus
);
  localparam int AW = W + LOG2_N;

  typedef enum logic [2:0] {IDLE, WAIT_FS, ACCUM, EMIT, DONE} state_t;

  state_t               state_q;
  logic [2:0]           ch_q;
  logic [LOG2_N-1:0]    frm_q;
  logic                 fs_q;
  logic signed [AW-1:0] acc_q [8];
  logic signed [W-1:0]  smp_q [8];
  logic                 busy_q;
  logic                 done_q;
  logic                 wr_en_q;
  logic [3:0]           wr_addr_q;
  logic [W-1:0]         wr_data_q;

  logic signed [W-1:0]  in_w [8];
  logic                 fs_edge;
  logic signed [AW-1:0] acc_d;

  assign in_w[0] = in0;
  assign in_w[1] = in1;
  assign in_w[2] = in2;
  assign in_w[3] = in3;
  assign in_w[4] = in4;
  assign in_w[5] = in5;
  assign in_w[6] = in6;
  assign in_w[7] = in7;

  assign fs_edge = clk_fs & ~fs_q;
  // The one shared adder, steered by ch_q across the eight ACCUM cycles.
  assign acc_d = acc_q[ch_q] + {{LOG2_N{smp_q[ch_q][W-1]}}, smp_q[ch_q]};

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      frm_q     <= '0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < 8; i++) begin
        acc_q[i] <= '0;
        smp_q[i] <= '0;
      end
    end else begin
      fs_q    <= clk_fs;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      if (bus.abort && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              for (int i = 0; i < 8; i++) acc_q[i] <= '0;
              frm_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= WAIT_FS;
            end
          end
          WAIT_FS: begin
            if (fs_edge) begin
              for (int i = 0; i < 8; i++) smp_q[i] <= in_w[i];
              ch_q    <= '0;
              state_q <= ACCUM;
            end
          end
          ACCUM: begin
            acc_q[ch_q] <= acc_d;
            ch_q        <= ch_q + 3'd1;
            if (ch_q == 3'd7) begin
              frm_q   <= frm_q + LOG2_N'(1);
              state_q <= (frm_q == '1) ? EMIT : WAIT_FS;
            end
          end
          EMIT: begin
            // Dropping the low LOG2_N bits is the arithmetic shift, rounding toward -inf.
            wr_en_q   <= 1'b1;
            wr_addr_q <= {ch_q, 1'b0};
            wr_data_q <= acc_q[ch_q][AW-1:LOG2_N];
            ch_q      <= ch_q + 3'd1;
            if (ch_q == 3'd7) state_q <= DONE;
          end
          DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_cal_offset_capture.sv
// tb/tb_cal_offset_capture.sv - directed vector bench for cal_offset_capture (W=16, LOG2_N=2)
module tb_cal_offset_capture;
  logic clk_256fs = 1'b0;
  logic rst_n = 1'b1;
  logic clk_fs = 1'b0;
  logic [3:0] fs_cnt = 4'd0;
  logic signed [15:0] in_v [8];

  cal_offset_capture_if #(.W(16)) bus ();

  cal_offset_capture #(.W(16), .LOG2_N(2)) dut (
    .clk_256fs(clk_256fs),
    .rst_n(rst_n),
    .clk_fs(clk_fs),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .bus(bus)
  );

  always #5 clk_256fs = ~clk_256fs;

  // Frame clock: 16 fast cycles per frame, enough room for the 8 ACCUM cycles.
  always @(negedge clk_256fs) begin
    fs_cnt = fs_cnt + 4'd1;
    clk_fs = fs_cnt[3];
  end

  typedef struct packed {
    logic [3:0][15:0] f0;
    logic [3:0][15:0] f1;
    logic [7:0][15:0] exp;
  } vec_t;

  vec_t vecs [4];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nw = 0;
  int nd = 0;
  int dc = 0;
  logic db = 1'b0;
  logic [3:0] wa [32];
  logic signed [15:0] wd [32];
  int wc [32];

  always @(negedge clk_256fs) begin
    cyc = cyc + 1;
    if (bus.wr_en && nw < 32) begin
      wa[nw] = bus.wr_addr;
      wd[nw] = bus.wr_data;
      wc[nw] = cyc;
      nw = nw + 1;
    end
    if (bus.done) begin
      nd = nd + 1;
      dc = cyc;
      db = bus.busy;
    end
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] mk4(input int a, input int b, input int c, input int d);
    logic [3:0][15:0] r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
    return r;
  endfunction

  function automatic logic [7:0][15:0] mk_exp(input int e0, input int e1);
    logic [7:0][15:0] r;
    r[0] = 16'(e0);
    r[1] = 16'(e1);
    for (int k = 2; k < 8; k++) r[k] = 16'(100 * (k + 1));
    return r;
  endfunction

  task automatic set_frame(input vec_t v, input int f);
    in_v[0] = $signed(v.f0[f]);
    in_v[1] = $signed(v.f1[f]);
    for (int k = 2; k < 8; k++) in_v[k] = 16'(100 * (k + 1));
  endtask

  task automatic pulse_start();
    @(negedge clk_256fs);
    bus.start = 1'b1;
    @(negedge clk_256fs);
    bus.start = 1'b0;
  endtask

  task automatic clear_log();
    nw = 0;
    nd = 0;
    dc = 0;
    db = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit extra_starts);
    int t;
    clear_log();
    @(negedge clk_fs);
    set_frame(v, 0);
    pulse_start();
    chk({tag, "_busy_after_start"}, 32'(bus.busy), 1);
    if (extra_starts) pulse_start();
    for (int f = 1; f < 4; f++) begin
      @(negedge clk_fs);
      set_frame(v, f);
      if (extra_starts) pulse_start();
    end
    t = 0;
    while (nd == 0 && t < 100) begin
      @(negedge clk_256fs);
      t++;
    end
    repeat (20) @(negedge clk_256fs);
    chk({tag, "_writes"}, nw, 8);
    chk({tag, "_done_count"}, nd, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < nw) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 2 * i);
        chk($sformatf("%s_data%0d", tag, i), wd[i], $signed(v.exp[i]));
        chk($sformatf("%s_consec%0d", tag, i), wc[i], wc[0] + i);
      end
    end
    if (nw >= 8 && nd >= 1) chk({tag, "_done_timing"}, dc, wc[7] + 1);
    if (nd >= 1) chk({tag, "_busy_at_done"}, 32'(db), 0);
    chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int snap;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 0; k < 8; k++) in_v[k] = '0;

    vecs[0].f0 = mk4(100, 100, 100, 100);
    vecs[0].f1 = mk4(-200, -200, -200, -200);
    vecs[0].exp = mk_exp(100, -200);
    vecs[1].f0 = mk4(3, 4, 3, 4);
    vecs[1].f1 = mk4(-1, -2, -1, -2);
    vecs[1].exp = mk_exp(3, -2);
    vecs[2].f0 = mk4(32767, 32767, 32767, 32767);
    vecs[2].f1 = mk4(-32768, -32768, -32768, -32768);
    vecs[2].exp = mk_exp(32767, -32768);
    vecs[3].f0 = mk4(-1, 0, 0, 0);
    vecs[3].f1 = mk4(1, 1, 1, 0);
    vecs[3].exp = mk_exp(-1, 0);

    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) @(negedge clk_256fs);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_256fs);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Abort in the third WAIT_FS: two frames counted, accumulation finished.
    clear_log();
    @(negedge clk_fs);
    set_frame(vecs[0], 0);
    pulse_start();
    @(posedge clk_fs);
    @(posedge clk_fs);
    repeat (12) @(negedge clk_256fs);
    chk("abort_busy_before", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    @(negedge clk_256fs);
    bus.abort = 1'b0;
    chk("abort_busy_after", 32'(bus.busy), 0);
    repeat (80) @(negedge clk_256fs);
    chk("abort_no_writes", nw, 0);
    chk("abort_no_done", nd, 0);
    run_vec(vecs[0], "after_abort", 1'b0);

    run_vec(vecs[1], "busy_starts", 1'b1);

    // Reset during EMIT, after two writes have gone out.
    clear_log();
    @(negedge clk_fs);
    set_frame(vecs[0], 0);
    pulse_start();
    t = 0;
    while (nw < 2 && t < 200) begin
      @(negedge clk_256fs);
      t++;
    end
    chk("emit_reached", 32'(nw >= 2), 1);
    rst_n = 1'b0;
    #1 chk_outputs_zero("mid_reset");
    repeat (3) @(negedge clk_256fs);
    rst_n = 1'b1;
    snap = nw;
    repeat (80) @(negedge clk_256fs);
    chk("mid_reset_no_writes", nw, snap);
    chk("mid_reset_no_done", nd, 0);
    run_vec(vecs[2], "after_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
